// File: rtl/inst_decode.sv
// RV32I decode stage: splits the instruction into fields, builds the immediate and reads the
// integer register file into the ID/EX pipeline register, with an optional write-back bypass.
module inst_decode #(
    parameter bit C_RESET_REGS = 1'b1,
    parameter bit C_WB_BYPASS  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] I_PC,
    input  logic [31:0] I_INST,
    input  logic        I_VALID,
    input  logic        WB_EN,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_DATA,
    output logic [31:0] D_PC,
    output logic [6:0]  D_OPCODE,
    output logic [4:0]  D_RD,
    output logic [2:0]  D_FUNCT3,
    output logic [4:0]  D_RS1,
    output logic [4:0]  D_RS2,
    output logic [6:0]  D_FUNCT7,
    output logic [31:0] D_IMM,
    output logic [31:0] D_RS1_DATA,
    output logic [31:0] D_RS2_DATA,
    output logic        D_VALID,
    output logic        D_ILLEGAL
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // ------------------------------------------------------------------
    // Register file: x0 is hard-wired to zero, x1..x31 are flops
    // ------------------------------------------------------------------
    logic [31:0] w_rf [32];
    logic        w_wb_fire;

    assign w_wb_fire = WB_EN && (WB_RD != 5'd0);
    assign w_rf[0]   = 32'd0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] r_x;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    if (C_RESET_REGS) begin
                        r_x <= 32'd0;
                    end
                end else if (w_wb_fire && (WB_RD == 5'(gi))) begin
                    r_x <= WB_DATA;
                end
            end
            assign w_rf[gi] = r_x;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    logic        w_legal;

    assign w_opcode = I_INST[6:0];
    assign w_rd     = I_INST[11:7];
    assign w_funct3 = I_INST[14:12];
    assign w_rs1    = I_INST[19:15];
    assign w_rs2    = I_INST[24:20];
    assign w_funct7 = I_INST[31:25];

    always_comb begin
        w_imm   = 32'd0;
        w_legal = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                w_imm   = {{20{I_INST[31]}}, I_INST[31:20]};
                w_legal = 1'b1;
            end
            OP_STORE: begin
                w_imm   = {{20{I_INST[31]}}, I_INST[31:25], I_INST[11:7]};
                w_legal = 1'b1;
            end
            OP_BRANCH: begin
                w_imm   = {{19{I_INST[31]}}, I_INST[31], I_INST[7], I_INST[30:25],
                           I_INST[11:8], 1'b0};
                w_legal = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm   = {I_INST[31:12], 12'd0};
                w_legal = 1'b1;
            end
            OP_JAL: begin
                w_imm   = {{11{I_INST[31]}}, I_INST[31], I_INST[19:12], I_INST[20],
                           I_INST[30:21], 1'b0};
                w_legal = 1'b1;
            end
            OP_REG, OP_FENCE: begin
                w_legal = 1'b1;
            end
            default: begin
                w_imm   = 32'd0;
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register reads: while stalled, re-read with the held source indices
    // so a write-back landing during the stall is picked up.
    // ------------------------------------------------------------------
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  w_rs1_addr;
    logic [4:0]  w_rs2_addr;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1_addr = STALL ? r_rs1 : w_rs1;
    assign w_rs2_addr = STALL ? r_rs2 : w_rs2;

    always_comb begin
        w_rs1_val = w_rf[w_rs1_addr];
        if (w_rs1_addr == 5'd0) begin
            w_rs1_val = 32'd0;
        end else if (C_WB_BYPASS && WB_EN && (WB_RD == w_rs1_addr)) begin
            w_rs1_val = WB_DATA;
        end
    end

    always_comb begin
        w_rs2_val = w_rf[w_rs2_addr];
        if (w_rs2_addr == 5'd0) begin
            w_rs2_val = 32'd0;
        end else if (C_WB_BYPASS && WB_EN && (WB_RD == w_rs2_addr)) begin
            w_rs2_val = WB_DATA;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_imm;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic        r_valid;
    logic        r_illegal;
    logic        w_bubble;

    // A flush, or an empty slot arriving while not stalled, both load a bubble.
    assign w_bubble = RST || FLUSH || (!STALL && !I_VALID);

    always_ff @(posedge CLK) begin
        if (w_bubble) begin
            r_pc       <= 32'd0;
            r_opcode   <= 7'd0;
            r_rd       <= 5'd0;
            r_funct3   <= 3'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_funct7   <= 7'd0;
            r_imm      <= 32'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_valid    <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (STALL) begin
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
        end else begin
            r_pc       <= I_PC;
            r_opcode   <= w_opcode;
            r_rd       <= w_rd;
            r_funct3   <= w_funct3;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_funct7   <= w_funct7;
            r_imm      <= w_imm;
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
            r_valid    <= 1'b1;
            r_illegal  <= !w_legal;
        end
    end

    assign D_PC       = r_pc;
    assign D_OPCODE   = r_opcode;
    assign D_RD       = r_rd;
    assign D_FUNCT3   = r_funct3;
    assign D_RS1      = r_rs1;
    assign D_RS2      = r_rs2;
    assign D_FUNCT7   = r_funct7;
    assign D_IMM      = r_imm;
    assign D_RS1_DATA = r_rs1_data;
    assign D_RS2_DATA = r_rs2_data;
    assign D_VALID    = r_valid;
    assign D_ILLEGAL  = r_illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Randomised bench for inst_decode: a reference model of the decode stage and register file
// predicts every output after each clock edge; directed steps pin the model with literal values.
module tb_inst_decode;

    logic        CLK = 1'b0;
    logic        RST, STALL, FLUSH, I_VALID, WB_EN;
    logic [31:0] I_PC, I_INST, WB_DATA;
    logic [4:0]  WB_RD;
    logic [31:0] D_PC, D_IMM, D_RS1_DATA, D_RS2_DATA;
    logic [6:0]  D_OPCODE, D_FUNCT7;
    logic [4:0]  D_RD, D_RS1, D_RS2;
    logic [2:0]  D_FUNCT3;
    logic        D_VALID, D_ILLEGAL;

    always #5 CLK = ~CLK;

    inst_decode #(.C_RESET_REGS(1'b1), .C_WB_BYPASS(1'b1)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
        .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .D_PC(D_PC), .D_OPCODE(D_OPCODE), .D_RD(D_RD), .D_FUNCT3(D_FUNCT3),
        .D_RS1(D_RS1), .D_RS2(D_RS2), .D_FUNCT7(D_FUNCT7), .D_IMM(D_IMM),
        .D_RS1_DATA(D_RS1_DATA), .D_RS2_DATA(D_RS2_DATA),
        .D_VALID(D_VALID), .D_ILLEGAL(D_ILLEGAL)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        valid;
        logic        ill;
    } slot_t;

    slot_t       exp_s;
    logic [31:0] m_rf [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_step   = 0;
    logic [6:0]  legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                    7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %08h, required %08h", nm, n_step, act, req);
        end
    endtask

    // Architectural read of register a as seen in a cycle carrying the given write-back.
    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic slot_t decode(input logic [31:0] pc, input logic [31:0] w);
        slot_t s;
        logic  ok;
        s = '0;
        s.pc = pc; s.opc = w[6:0]; s.rd = w[11:7]; s.f3 = w[14:12];
        s.rs1 = w[19:15]; s.rs2 = w[24:20]; s.f7 = w[31:25]; s.valid = 1'b1;
        ok = 1'b0;
        foreach (legal_ops[k]) if (legal_ops[k] == w[6:0]) ok = 1'b1;
        s.ill = !ok;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: s.imm = 32'($signed(w[31:20]));
            7'h23: s.imm = 32'($signed({w[31:25], w[11:7]}));
            7'h63: s.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            7'h37, 7'h17: s.imm = {w[31:12], 12'd0};
            7'h6F: s.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: s.imm = 32'd0;
        endcase
        return s;
    endfunction

    task automatic step(input logic rst, input logic stall, input logic flush,
                        input logic [31:0] pc, input logic [31:0] inst, input logic vld,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        RST = rst; STALL = stall; FLUSH = flush; I_PC = pc; I_INST = inst; I_VALID = vld;
        WB_EN = we; WB_RD = wa; WB_DATA = wd;
        if (rst) begin
            exp_s = '0;
            foreach (m_rf[k]) m_rf[k] = 32'd0;
        end else begin
            if (flush || (!stall && !vld)) begin
                exp_s = '0;
            end else if (stall) begin
                exp_s.d1 = mread(exp_s.rs1, we, wa, wd);
                exp_s.d2 = mread(exp_s.rs2, we, wa, wd);
            end else begin
                exp_s = decode(pc, inst);
                exp_s.d1 = mread(inst[19:15], we, wa, wd);
                exp_s.d2 = mread(inst[24:20], we, wa, wd);
            end
            if (we && wa != 0) m_rf[wa] = wd;
        end
        @(posedge CLK);
        #1;
        n_step++;
        $display("step %0d rst=%0b stall=%0b flush=%0b vld=%0b inst=%08h wb=%0b x%0d=%08h -> v=%0b ill=%0b imm=%08h",
                 n_step, rst, stall, flush, vld, inst, we, wa, wd, D_VALID, D_ILLEGAL, D_IMM);
        cmp("D_PC", D_PC, exp_s.pc);
        cmp("D_OPCODE", 32'(D_OPCODE), 32'(exp_s.opc));
        cmp("D_RD", 32'(D_RD), 32'(exp_s.rd));
        cmp("D_FUNCT3", 32'(D_FUNCT3), 32'(exp_s.f3));
        cmp("D_RS1", 32'(D_RS1), 32'(exp_s.rs1));
        cmp("D_RS2", 32'(D_RS2), 32'(exp_s.rs2));
        cmp("D_FUNCT7", 32'(D_FUNCT7), 32'(exp_s.f7));
        cmp("D_IMM", D_IMM, exp_s.imm);
        cmp("D_RS1_DATA", D_RS1_DATA, exp_s.d1);
        cmp("D_RS2_DATA", D_RS2_DATA, exp_s.d2);
        cmp("D_VALID", 32'(D_VALID), 32'(exp_s.valid));
        cmp("D_ILLEGAL", 32'(D_ILLEGAL), 32'(exp_s.ill));
    endtask

    initial begin
        logic [31:0] inst, pc;
        logic [4:0]  wa;
        logic        st, fl, rs, vl, we;

        RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; I_PC = 32'd0; I_INST = 32'd0;
        I_VALID = 1'b0; WB_EN = 1'b0; WB_RD = 5'd0; WB_DATA = 32'd0;

        // Reset, then hand-checked decodes
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        cmp("lit_reset_valid", 32'(D_VALID), 32'd0);
        cmp("lit_reset_pc", D_PC, 32'd0);
        step(0, 0, 0, 32'h20000000, 32'h00500093, 1, 0, 0, 32'h0);
        cmp("lit_addi_opcode", 32'(D_OPCODE), 32'h13);
        cmp("lit_addi_rd", 32'(D_RD), 32'd1);
        cmp("lit_addi_imm", D_IMM, 32'd5);
        cmp("lit_addi_pc", D_PC, 32'h20000000);
        cmp("lit_addi_illegal", 32'(D_ILLEGAL), 32'd0);
        step(0, 0, 0, 32'h20000004, 32'hFE208CE3, 1, 0, 0, 32'h0);
        cmp("lit_beq_imm", D_IMM, 32'hFFFFFFF8);
        cmp("lit_beq_rs1", 32'(D_RS1), 32'd1);
        cmp("lit_beq_rs2", 32'(D_RS2), 32'd2);
        step(0, 0, 0, 32'h20000008, 32'h123452B7, 1, 0, 0, 32'h0);
        cmp("lit_lui_imm", D_IMM, 32'h12345000);

        // Write-back bypass and x0
        step(0, 0, 0, 32'h2000000C, 32'h00008113, 1, 1, 5'd1, 32'hDEADBEEF);
        cmp("lit_bypass", D_RS1_DATA, 32'hDEADBEEF);
        step(0, 0, 0, 32'h20000010, 32'h00000093, 1, 1, 5'd0, 32'd7);
        cmp("lit_x0_read", D_RS1_DATA, 32'd0);
        step(0, 0, 0, 32'h20000014, 32'h00008113, 1, 0, 0, 32'h0);
        cmp("lit_x1_stored", D_RS1_DATA, 32'hDEADBEEF);

        // Stall for 3 cycles, write-back to the held rs1 in the second
        step(0, 0, 0, 32'h00000100, 32'h00118213, 1, 0, 0, 32'h0);
        step(0, 1, 0, 32'h00000200, 32'h00500093, 1, 0, 0, 32'h0);
        cmp("lit_stall1_data", D_RS1_DATA, 32'd0);
        step(0, 1, 0, 32'h00000204, 32'h00500093, 1, 1, 5'd3, 32'hCAFEF00D);
        cmp("lit_stall2_data", D_RS1_DATA, 32'hCAFEF00D);
        step(0, 1, 0, 32'h00000208, 32'h00500093, 1, 0, 0, 32'h0);
        cmp("lit_stall_pc", D_PC, 32'h00000100);
        cmp("lit_stall_imm", D_IMM, 32'd1);
        cmp("lit_stall_valid", 32'(D_VALID), 32'd1);

        // Flush beats stall; invalid input is a bubble
        step(0, 1, 1, 32'h00000300, 32'h00500093, 1, 0, 0, 32'h0);
        cmp("lit_flush_valid", 32'(D_VALID), 32'd0);
        cmp("lit_flush_imm", D_IMM, 32'd0);
        step(0, 0, 0, 32'h00000304, 32'h00500093, 0, 0, 0, 32'h0);
        cmp("lit_bubble_valid", 32'(D_VALID), 32'd0);

        // Illegal opcode, then reset in the middle of a stall
        step(0, 0, 0, 32'h00000400, 32'hFFFFFFFF, 1, 0, 0, 32'h0);
        cmp("lit_illegal", 32'(D_ILLEGAL), 32'd1);
        cmp("lit_illegal_valid", 32'(D_VALID), 32'd1);
        cmp("lit_illegal_imm", D_IMM, 32'd0);
        step(0, 0, 0, 32'h00000404, 32'h00118213, 1, 0, 0, 32'h0);
        step(1, 1, 0, 32'h00000408, 32'h00500093, 1, 1, 5'd3, 32'h11111111);
        cmp("lit_rst_valid", 32'(D_VALID), 32'd0);
        cmp("lit_rst_pc", D_PC, 32'd0);
        step(0, 0, 0, 32'h00000500, 32'h00008113, 1, 0, 0, 32'h0);
        cmp("lit_regs_cleared", D_RS1_DATA, 32'd0);

        // Randomised traffic
        pc = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            inst = $urandom;
            if ($urandom_range(0, 9) < 8) inst[6:0] = legal_ops[$urandom_range(0, 10)];
            rs = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 8);
            vl = ($urandom_range(0, 99) < 85);
            we = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: wa = inst[19:15];
                1: wa = exp_s.rs1;
                2: wa = exp_s.rs2;
                default: wa = 5'($urandom);
            endcase
            step(rs, st, fl, pc, inst, vl, we, wa, $urandom);
            pc = pc + 32'd4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
- RV32I decode stage; sits directly downstream of inst_fetch and consumes its I_PC / I_INST / I_VALID.
- Registers the decoded fields, immediate and register-file read data into the ID/EX pipeline register.
- Owns the 32x32 integer register file, with a write-back port and same-cycle write-back bypass.
- Honours the pipeline-wide STALL / FLUSH controls in the same way as fetch.

Parameters:
C_RESET_REGS, 1, 1: synchronous reset clears x1..x31 to 0; 0: register contents untouched by reset
C_WB_BYPASS, 1, 1: a write-back in the same cycle as a read forwards WB_DATA to the read; 0: the read returns the old value

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous, active-high reset
STALL  in  1  hold the pipeline register
FLUSH  in  1  squash: next output is a bubble
I_PC  in  32  PC of the incoming instruction
I_INST  in  32  incoming instruction word
I_VALID  in  1  incoming instruction valid
WB_EN  in  1  register write enable
WB_RD  in  5  write address
WB_DATA  in  32  write data
D_PC  out  32  registered PC
D_OPCODE  out  7  inst[6:0]
D_RD  out  5  inst[11:7]
D_FUNCT3  out  3  inst[14:12]
D_RS1  out  5  inst[19:15]
D_RS2  out  5  inst[24:20]
D_FUNCT7  out  7  inst[31:25]
D_IMM  out  32  sign-extended immediate
D_RS1_DATA  out  32  value of rs1
D_RS2_DATA  out  32  value of rs2
D_VALID  out  1  output slot holds an instruction
D_ILLEGAL  out  1  opcode not RV32I

Behaviour:
- Reset:
  - All D_* outputs are 0; D_VALID=0.
  - If C_RESET_REGS=1, x1..x31 are 0 after reset.
- Latency: 1 cycle from I_* to D_*. All outputs come from registers; there are no combinational paths from inputs to outputs.
- Priority per cycle: RST > FLUSH > STALL > load.
  - FLUSH=1: next cycle D_VALID=0, D_ILLEGAL=0, all fields/IMM/DATA=0, regardless of STALL.
  - STALL=1 (no FLUSH): D_PC, fields, IMM, VALID and ILLEGAL hold. D_RS1_DATA/D_RS2_DATA re-read every cycle using the held D_RS1/D_RS2, so a write-back landing during a stall is reflected.
  - Load: if I_VALID=0, load a bubble (same as flush). Otherwise capture the decode of I_INST.
- Immediate, by opcode:
  - I-type (0x03, 0x13, 0x67, 0x73): sext(inst[31:20]).
  - S-type (0x23): sext({inst[31:25], inst[11:7]}).
  - B-type (0x63): sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U-type (0x37, 0x17): {inst[31:12], 12'b0}.
  - J-type (0x6F): sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Other opcodes, including 0x33 R-type and 0x0F fence: 0.
- Legal opcodes: 0x03, 0x0F, 0x13, 0x17, 0x23, 0x33, 0x37, 0x63, 0x67, 0x6F, 0x73.
  - Any other opcode with I_VALID=1 gives D_VALID=1, D_ILLEGAL=1.
  - funct3/funct7 are not checked.
- Register file:
  - Write when WB_EN=1 and WB_RD!=0. Writes to x0 are ignored; x0 always reads 0.
  - Writes occur during STALL and FLUSH.
  - RST has priority over WB_EN; no write occurs in a reset cycle.
- Read value:
  - rs==0 reads 0.
  - If C_WB_BYPASS=1 and WB_EN=1 and WB_RD==rs!=0, the read returns WB_DATA.
  - Otherwise the read returns the stored value.
- Reset mid-stall: reset wins, outputs are cleared, and stall state is not retained.

Test Plan:
- Reset, then I_INST=0x00500093 (addi x1,x0,5), I_PC=0x20000000, I_VALID=1 -> next cycle D_VALID=1, D_OPCODE=0x13, D_RD=1, D_RS1=0, D_IMM=5, D_PC=0x20000000, D_ILLEGAL=0.
- I_INST=0xFE208CE3 (beq x1,x2,-8) -> D_IMM=0xFFFFFFF8, D_RS1=1, D_RS2=2, D_FUNCT3=0. I_INST=0x123452B7 (lui x5) -> D_IMM=0x12345000.
- Write-back bypass: WB_EN=1, WB_RD=1, WB_DATA=0xDEADBEEF in the same cycle that addi x2,x1,0 is loaded -> D_RS1_DATA=0xDEADBEEF. WB_RD=0, WB_DATA=7, then read x0 -> 0.
- STALL held 3 cycles with WB to D_RS1 in cycle 2 -> D_PC, D_IMM and D_VALID are unchanged; D_RS1_DATA shows the new value from the following cycle.
- FLUSH=1 together with STALL=1 and a valid I_INST -> next D_VALID=0, D_IMM=0. I_VALID=0 -> bubble.
- I_INST=0xFFFFFFFF, I_VALID=1 -> D_VALID=1, D_ILLEGAL=1, D_IMM=0. Assert RST mid-stream -> all outputs 0 the next cycle.
